// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and helpers for the pipeline credit FIFO slice.
//   - guard_state_e : post-reset guard state (GUARD while stale results may
//                     still drain out of the unreset upstream pipeline, RUN after)
//   - clog2_depth() : counter/pointer width helper, never narrower than 1 bit
// -----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    RUN   = 1'b1
  } guard_state_e;

  // Width needed to index n distinct values; clamped to 1 so degenerate
  // parameterisations (n <= 1) still produce a legal vector.
  function automatic int unsigned clog2_depth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// pipeline_sync_fifo_mem
//   DEPTH x DW storage array: one synchronous write port, one asynchronous
//   read port. The array itself has no reset; contents are undefined until
//   written.
//
// Ports
//   clk      in   clock, write on rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], combinational
// -----------------------------------------------------------------------------
module pipeline_sync_fifo_mem
  import pipeline_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = clog2_depth(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipeline_credit_fifo.sv
// -----------------------------------------------------------------------------
// pipeline_credit_fifo
//   Return buffer behind a fixed-latency, non-stallable pipeline. Issue into
//   the pipeline is metered by a credit counter (in-flight + stored items) so
//   every returning result is guaranteed a storage slot. Results are presented
//   on a valid/ready output in strict FIFO order.
//
// Parameters
//   DW       data width
//   LATENCY  issue-to-return latency of the upstream pipeline (>= 0)
//   DEPTH    storage entries and total credits (>= 1)
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   issue_valid  in   upstream wants to launch an item
//   issue_ready  out  credit available (and post-reset guard finished)
//   in_valid     in   pipeline result valid
//   in_data      in   pipeline result
//   out_valid    out  head entry available
//   o_data       out  head entry data
//   out_ready    in   consumer accepts head entry
//   overflow     out  sticky: write arrived while full with no read
//
// Build option
//   PIPELINE_CREDIT_FIFO_FWFT_EN  when defined, an arriving word is shown on
//   the output in the same cycle if the buffer is empty, and bypasses storage
//   when accepted immediately. Undefined: registered output.
// -----------------------------------------------------------------------------
module pipeline_credit_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] o_data,
  input  logic          out_ready,
  output logic          overflow
);

  localparam int unsigned PTR_W = clog2_depth(DEPTH);
  localparam int unsigned CNT_W = clog2_depth(DEPTH + 1);
  localparam int unsigned GRD_W = clog2_depth(LATENCY + 1);

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [GRD_W-1:0] GRD_INIT   = GRD_W'(LATENCY);
  localparam guard_state_e     STATE_INIT = (LATENCY == 0) ? RUN : GUARD;

`ifdef PIPELINE_CREDIT_FIFO_FWFT_EN
  localparam int unsigned TPUT_MIN_DEPTH = LATENCY + 1;
`else
  localparam int unsigned TPUT_MIN_DEPTH = LATENCY + 2;
`endif

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DEPTH < 1) begin : g_depth_err
    $error("pipeline_credit_fifo: DEPTH must be at least 1");
  end

  if (DEPTH < TPUT_MIN_DEPTH) begin : g_tput_warn
    $warning("pipeline_credit_fifo: DEPTH=%0d is below %0d, issue will not sustain full throughput",
             DEPTH, TPUT_MIN_DEPTH);
  end

  // Circular-buffer pointer increment; explicit wrap handles non-power-of-2 DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  guard_state_e     state_q;
  logic [GRD_W-1:0] guard_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] used_q;
  logic             out_valid_q;
  logic [DW-1:0]    o_data_q;
  logic             overflow_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic             guard_done;
  logic             in_acc;
  logic             issue_fire;
  logic             out_fire;
  logic             bypass;
  logic             rd_en;
  logic             wr_en;
  logic             full;
  logic             ovf_evt;
  logic             head_new;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] used_d;
  logic [DW-1:0]    mem_rd_data;
  logic [DW-1:0]    head_data;

  assign guard_done = (state_q == RUN);

  // rst_n is folded in so that with LATENCY=0 (no guard) nothing is accepted
  // or offered while reset is held.
  assign in_acc      = in_valid & guard_done & rst_n;
  assign issue_ready = (used_q < CNT_FULL) & guard_done & rst_n;
  assign issue_fire  = issue_valid & issue_ready;

`ifdef PIPELINE_CREDIT_FIFO_FWFT_EN
  logic show_in;

  // Empty buffer: present the arriving word directly. If it is taken this
  // cycle it never touches storage.
  assign show_in   = (count_q == '0) & in_acc;
  assign out_valid = out_valid_q | show_in;
  assign o_data    = show_in ? in_data : o_data_q;
  assign bypass    = show_in & out_ready;
`else
  assign out_valid = out_valid_q;
  assign o_data    = o_data_q;
  assign bypass    = 1'b0;
`endif

  assign out_fire = out_valid & out_ready;
  assign rd_en    = out_fire & ~bypass;
  assign full     = (count_q == CNT_FULL);

  // A write while full only lands if the head leaves in the same cycle.
  assign wr_en    = in_acc & ~bypass & (~full | rd_en);
  assign ovf_evt  = in_acc & full & ~rd_en;

  assign rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  assign used_d   = used_q + CNT_W'(issue_fire) - CNT_W'(out_fire);

  // The next head is the word being written now exactly when nothing else
  // remains stored after this cycle's read. This also covers DEPTH=1 where a
  // full write+read lands on the same slot the head is read from.
  assign head_new  = wr_en & (count_q == CNT_W'(rd_en));
  assign head_data = head_new ? in_data : mem_rd_data;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  pipeline_sync_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_d),
    .rd_data (mem_rd_data)
  );

  // ---------------------------------------------------------------------------
  // Post-reset guard: count LATENCY cycles so results launched before reset
  // by the unreset pipeline are discarded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STATE_INIT;
      guard_q <= GRD_INIT;
    end else if (state_q == GUARD) begin
      guard_q <= guard_q - GRD_W'(1);
      if (guard_q == GRD_W'(1)) begin
        state_q <= RUN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, credits and registered output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      used_q      <= '0;
      out_valid_q <= 1'b0;
      o_data_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      used_q      <= used_d;
      // Output register mirrors the head of the post-update buffer, so it
      // holds steady under backpressure and o_data keeps its last value
      // when the buffer drains.
      out_valid_q <= (count_d != '0);
      if (count_d != '0) begin
        o_data_q <= head_data;
      end
      if (ovf_evt) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign overflow = overflow_q;

endmodule
